// File: rtl/serial_signed_pow2_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_signed_pow2_divider_pkg
// Brief    : Shared FSM state type and rounding-mode encodings for the
//            serial signed power-of-two divider.
// Revision : 1.0  initial release
// ============================================================================
package serial_signed_pow2_divider_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_FLOOR = 1'b0;
    localparam logic MODE_TRUNC = 1'b1;

endpackage
`default_nettype wire

// File: rtl/serial_signed_pow2_divider_shift.sv
`default_nettype none
// ============================================================================
// Module   : arithmetic_shift_right_by_one
// Brief    : One-bit arithmetic right shift with the shifted-out LSB exposed.
// Revision : 1.0  initial release
// ============================================================================
module arithmetic_shift_right_by_one
    import serial_signed_pow2_divider_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] din,
    output logic [N-1:0] dout,
    output logic         shifted_out
);

    assign dout        = {din[N-1], din[N-1:1]};
    assign shifted_out = din[0];

endmodule
`default_nettype wire

// File: rtl/serial_signed_pow2_divider.sv
`default_nettype none
// ============================================================================
// Module   : serial_signed_pow2_divider
// Brief    : Bit-serial signed divide by 2^k with floor or truncate rounding,
//            valid/ready handshakes on both sides.
// Revision : 1.0  initial release
// ============================================================================
module serial_signed_pow2_divider
    import serial_signed_pow2_divider_pkg::*;
#(
    parameter  int N  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_data,
    input  logic [SW-1:0] up_shamt,
    input  logic          up_mode,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_data
);

    localparam logic [SW-1:0] CNT_ONE = {{(SW-1){1'b0}}, 1'b1};

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  acc;
    logic [SW-1:0] cnt;
    logic          mode;
    logic          sticky;

    logic [N-1:0]  shifted;
    logic          shift_out;
    logic          sticky_next;
    logic          last_shift;
    logic          correct;
    logic [N-1:0]  acc_next;
    logic          accept;

    arithmetic_shift_right_by_one #(
        .N (N)
    ) u_asr1 (
        .din         (acc),
        .dout        (shifted),
        .shifted_out (shift_out)
    );

    // Truncation differs from floor only for negative values that lost a 1 bit;
    // the +1 cannot overflow because the shifted value is then strictly negative.
    assign sticky_next = sticky | shift_out;
    assign last_shift  = (cnt == CNT_ONE);
    assign correct     = last_shift && (mode == MODE_TRUNC) && shifted[N-1] && sticky_next;
    assign acc_next    = shifted + {{(N-1){1'b0}}, correct};
    assign accept      = up_valid && up_ready;
    assign down_data   = acc;

    always_comb begin
        state_next = state;
        up_ready   = 1'b0;
        down_valid = 1'b0;
        case (state)
            IDLE: begin
                up_ready = !rst;
                if (up_valid && !rst) begin
                    state_next = (up_shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (last_shift) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                down_valid = 1'b1;
                if (down_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            mode   <= MODE_FLOOR;
            sticky <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc    <= up_data;
                        cnt    <= up_shamt;
                        mode   <= up_mode;
                        sticky <= 1'b0;
                    end
                end
                SHIFT: begin
                    acc    <= acc_next;
                    sticky <= sticky_next;
                    cnt    <= cnt - CNT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_signed_pow2_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_signed_pow2_divider
// Brief    : Scoreboard bench: directed corner cases plus randomized requests
//            checked against an integer-arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_signed_pow2_divider;

    localparam int N  = 8;
    localparam int SW = $clog2(N);

    logic          clk;
    logic          rst;
    logic          up_valid;
    logic          up_ready;
    logic [N-1:0]  up_data;
    logic [SW-1:0] up_shamt;
    logic          up_mode;
    logic          down_valid;
    logic          down_ready;
    logic [N-1:0]  down_data;

    serial_signed_pow2_divider #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_shamt   (up_shamt),
        .up_mode    (up_mode),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data)
    );

    typedef struct {
        logic [N-1:0] q;
        int           acc_cyc;
        int           k;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;
    int   hs_cyc = 0;
    int   first_cyc = 0;
    bit   in_xfer = 0;
    logic [N-1:0] held;
    bit   auto_ready;
    bit   stall_en;
    bit   manual_ready;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        down_ready = auto_ready ? (stall_en ? ($urandom_range(0, 3) != 0) : 1'b1) : manual_ready;
    end

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference: exact integer division, then floor adjustment for negative remainders.
    function automatic logic [N-1:0] ref_div(input logic [N-1:0] a, input int k, input logic m);
        int av, p, q;
        av = int'($signed(a));
        p  = 1 << k;
        q  = av / p;
        if (!m && (av % p != 0) && av < 0) q = q - 1;
        return q[N-1:0];
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [N-1:0] a, input int k, input logic m,
                        input logic [N-1:0] expq, output int acc_cyc);
        int   w;
        exp_t e;
        up_valid = 1'b1;
        up_data  = a;
        up_shamt = SW'(k);
        up_mode  = m;
        w        = 0;
        acc_cyc  = -1;
        while (acc_cyc < 0 && w < 100) begin
            @(negedge clk);
            if (up_ready) begin
                acc_cyc   = cyc;
                e.q       = expq;
                e.acc_cyc = cyc;
                e.k       = k;
                sb.push_back(e);
            end
            w++;
        end
        if (acc_cyc < 0) chk(0, "accept_timeout", w, 0);
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        up_data  = N'($urandom);
        up_shamt = SW'($urandom);
        up_mode  = 1'($urandom);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk(sb.size() == 0, "drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            in_xfer = 0;
        end else if (down_valid) begin
            if (in_xfer) chk(down_data == held, "hold_stable", $signed(down_data), $signed(held));
            else begin
                in_xfer   = 1;
                first_cyc = cyc;
            end
            held = down_data;
            chk(!up_ready, "up_ready_in_done", up_ready, 0);
            if (down_ready) begin
                in_xfer = 0;
                hs_cyc  = cyc;
                if (sb.size() == 0) begin
                    chk(0, "unexpected_result", $signed(down_data), 0);
                end else begin
                    e = sb.pop_front();
                    chk(down_data == e.q, "quotient", $signed(down_data), $signed(e.q));
                    chk(first_cyc - e.acc_cyc == e.k + 1, "latency", first_cyc - e.acc_cyc, e.k + 1);
                end
            end
        end
    end

    typedef struct {
        logic [N-1:0] a;
        int           k;
        logic         m;
        logic [N-1:0] q;
    } vec_t;

    initial begin
        vec_t vecs[$];
        int   ac, ac2, hs, nvalid, w;
        logic [N-1:0] a;
        int   k;
        logic m;

        rst = 1'b1; up_valid = 1'b0; up_data = '0; up_shamt = '0; up_mode = 1'b0;
        down_ready = 1'b0; auto_ready = 1; stall_en = 0; manual_ready = 0;

        repeat (2) @(negedge clk);
        chk(up_ready == 1'b0, "rst_up_ready", up_ready, 0);
        chk(down_valid == 1'b0, "rst_down_valid", down_valid, 0);
        chk(down_data == '0, "rst_down_data", down_data, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk(up_ready == 1'b1, "up_ready_after_rst", up_ready, 1);
        @(posedge clk); #1;

        vecs = '{
            '{8'hF9, 1, 1'b0, 8'hFC},   // -7  k1 floor -> -4
            '{8'hF9, 1, 1'b1, 8'hFD},   // -7  k1 trunc -> -3
            '{8'hFF, 3, 1'b0, 8'hFF},   // -1  k3 floor -> -1
            '{8'hFF, 3, 1'b1, 8'h00},   // -1  k3 trunc -> 0
            '{8'h7F, 7, 1'b0, 8'h00},
            '{8'h7F, 7, 1'b1, 8'h00},
            '{8'h80, 7, 1'b0, 8'hFF},   // -128 k7 -> -1 both modes
            '{8'h80, 7, 1'b1, 8'hFF},
            '{8'h80, 0, 1'b0, 8'h80},   // k0 passes through
            '{8'h80, 0, 1'b1, 8'h80},
            '{8'h9C, 6, 1'b0, 8'hFE},   // -100 k6 floor -> -2
            '{8'h9C, 6, 1'b1, 8'hFF}    // -100 k6 trunc -> -1
        };
        foreach (vecs[i]) send(vecs[i].a, vecs[i].k, vecs[i].m, vecs[i].q, ac);
        drain();

        // Hold the result 5 cycles with a second request already waiting.
        auto_ready = 0; manual_ready = 0;
        @(posedge clk); #1;
        send(8'hF9, 1, 1'b1, 8'hFD, ac);
        fork
            send(8'hF9, 1, 1'b0, 8'hFC, ac2);
            begin
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (!down_valid && w < 20);
                repeat (4) @(negedge clk);
                manual_ready = 1;
                @(negedge clk);
                auto_ready = 1;
            end
        join
        hs = hs_cyc;
        chk(ac2 == hs + 1, "accept_after_release", ac2, hs + 1);
        drain();

        // Reset during the third SHIFT cycle of a k=6 request.
        send(8'h9C, 6, 1'b1, 8'hFF, ac);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk(down_valid == 1'b0, "async_rst_down_valid", down_valid, 0);
        chk(down_data == '0, "async_rst_down_data", down_data, 0);
        chk(up_ready == 1'b0, "async_rst_up_ready", up_ready, 0);
        sb.delete();
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk(up_ready == 1'b1, "up_ready_after_abort", up_ready, 1);
        nvalid = 0;
        repeat (10) begin
            @(negedge clk);
            if (down_valid) nvalid++;
        end
        chk(nvalid == 0, "no_result_after_abort", nvalid, 0);
        @(posedge clk); #1;
        send(8'h9C, 6, 1'b0, 8'hFE, ac);
        drain();

        // Randomized traffic with consumer stalls.
        stall_en = 1;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 7))
                0:       a = 8'h80;
                1:       a = 8'h7F;
                2:       a = 8'hFF;
                default: a = N'($urandom);
            endcase
            k = $urandom_range(0, N - 1);
            m = 1'($urandom);
            send(a, k, m, ref_div(a, k, m), ac);
        end
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
